// File: rtl/bus_cmd_master_pkg.sv
// Shared bus field layout for the command master.
// Positions of every bus_in / bus_out field live here.
package bus_cmd_master_pkg;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_BE_WIDTH   = 4;

    // bus_in: request vector toward the slave
    localparam int BUS_FIELD_CLK     = 0;
    localparam int BUS_FIELD_RESET_L = 1;
    localparam int BUS_FIELD_RD_REQ  = 2;
    localparam int BUS_FIELD_WR_REQ  = 3;
    localparam int BUS_ADDR_START    = 4;
    localparam int BUS_ADDR_END      = BUS_ADDR_START + BUS_ADDR_WIDTH - 1;
    localparam int BUS_WDATA_START   = BUS_ADDR_END + 1;
    localparam int BUS_WDATA_END     = BUS_WDATA_START + BUS_DATA_WIDTH - 1;
    localparam int BUS_BE_START      = BUS_WDATA_END + 1;
    localparam int BUS_BE_END        = BUS_BE_START + BUS_BE_WIDTH - 1;
    localparam int BUS_IN_WIDTH      = BUS_BE_END + 1;

    // bus_out: return vector from the slave
    localparam int BUS_FIELD_RD_ACK = 0;
    localparam int BUS_FIELD_WR_ACK = 1;
    localparam int BUS_FIELD_IRQ    = 2;
    localparam int BUS_RDATA_START  = 3;
    localparam int BUS_RDATA_END    = BUS_RDATA_START + BUS_DATA_WIDTH - 1;
    localparam int BUS_OUT_WIDTH    = BUS_RDATA_END + 1;

endpackage

// File: rtl/bus_cmd_master.sv
// Single-outstanding bus command master with ack timeout.
// One command in, one request pulse out, one response strobe back.
module bus_cmd_master
    import bus_cmd_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]                cmd_be,
    output logic                      rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic [BUS_IN_WIDTH-1:0]   bus_in,
    input  logic [BUS_OUT_WIDTH-1:0]  bus_out,
    output logic                      irq
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      write_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                be_q;
    logic [BUS_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic                      accept;
    logic                      finish;
    logic                      fin_err;
    logic [BUS_DATA_WIDTH-1:0] fin_rdata;
    logic                      ack_ok;
    logic                      in_wait;
    logic                      first_wait;
    logic [BUS_DATA_WIDTH-1:0] bus_rdata;

    assign bus_rdata  = bus_out[BUS_RDATA_END:BUS_RDATA_START];
    assign irq        = bus_out[BUS_FIELD_IRQ];
    assign ack_ok     = write_q ? bus_out[BUS_FIELD_WR_ACK]
                                : bus_out[BUS_FIELD_RD_ACK];
    assign in_wait    = (state_q == S_WAIT);
    assign first_wait = in_wait && (cnt_q == '0);

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; a completing ack beats a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        finish    = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_ok) begin
                    finish    = 1'b1;
                    fin_rdata = write_q ? '0 : bus_rdata;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command capture on accept, response capture on finish.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                be_q    <= cmd_be;
            end
            if (finish) begin
                rdata_q <= fin_rdata;
                err_q   <= fin_err;
            end
        end
    end

    // Request vector; address/data/be only visible while waiting.
    always_comb begin
        bus_in = '0;
        bus_in[BUS_FIELD_CLK]     = clk;
        bus_in[BUS_FIELD_RESET_L] = reset_l;
        bus_in[BUS_FIELD_RD_REQ]  = first_wait & ~write_q;
        bus_in[BUS_FIELD_WR_REQ]  = first_wait & write_q;
        if (in_wait) begin
            bus_in[BUS_ADDR_END:BUS_ADDR_START]   = addr_q;
            bus_in[BUS_WDATA_END:BUS_WDATA_START] = wdata_q;
            bus_in[BUS_BE_END:BUS_BE_START]       = be_q;
        end
    end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master (TIMEOUT=8).
// Hand-computed expectations for each scenario.
module tb_bus_cmd_master;
    import bus_cmd_master_pkg::*;

    logic                      clk;
    logic                      reset_l;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [BUS_ADDR_WIDTH-1:0] cmd_addr;
    logic [BUS_DATA_WIDTH-1:0] cmd_wdata;
    logic [3:0]                cmd_be;
    logic                      rsp_valid;
    logic [BUS_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic [BUS_IN_WIDTH-1:0]   bus_in;
    logic [BUS_OUT_WIDTH-1:0]  bus_out;
    logic                      irq;

    logic                      rd_ack;
    logic                      wr_ack;
    logic                      irq_in;
    logic [BUS_DATA_WIDTH-1:0] slv_rdata;

    int checks;
    int failures;

    assign bus_out = {slv_rdata, irq_in, wr_ack, rd_ack};

    bus_cmd_master #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_be    (cmd_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BUS_BE_END:BUS_FIELD_RD_REQ] req_fields();
        return bus_in[BUS_BE_END:BUS_FIELD_RD_REQ];
    endfunction

    // One transaction; exp_idx = WAIT cycles before RESP is seen.
    task automatic txn(input string tag, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int ack_kind,
                       input int ack_at, input logic [31:0] ack_data,
                       input int exp_idx, input logic [31:0] exp_rdata,
                       input logic exp_err);
        int idx;
        idx = -1;
        @(negedge clk);
        chk({tag, "_rdy_idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        slv_rdata = ack_data;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                idx = i;
                chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
                chk({tag, "_err"}, rsp_err, exp_err);
                chk({tag, "_rdy_resp"}, cmd_ready, 1'b0);
            end else begin
                chk({tag, "_rdy_wait"}, cmd_ready, 1'b0);
                chk({tag, "_rdreq"}, bus_in[BUS_FIELD_RD_REQ],
                    (i == 0) && !wr);
                chk({tag, "_wrreq"}, bus_in[BUS_FIELD_WR_REQ],
                    (i == 0) && wr);
                chk({tag, "_addr"}, bus_in[BUS_ADDR_END:BUS_ADDR_START],
                    addr);
                chk({tag, "_wdata"},
                    bus_in[BUS_WDATA_END:BUS_WDATA_START], wdata);
                chk({tag, "_be"}, bus_in[BUS_BE_END:BUS_BE_START], be);
                rd_ack = (ack_kind == 1) && (i == ack_at);
                wr_ack = (ack_kind == 2) && (i == ack_at);
            end
        end
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        chk({tag, "_resp_cycle"}, idx, exp_idx);
        @(negedge clk);
        chk({tag, "_rv_after"}, rsp_valid, 1'b0);
        chk({tag, "_rdy_after"}, cmd_ready, 1'b1);
        chk({tag, "_req_idle"}, req_fields(), '0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        reset_l   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = '0;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        irq_in    = 1'b0;
        slv_rdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rv", rsp_valid, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_req", req_fields(), '0);
        chk("rst_field", bus_in[BUS_FIELD_RESET_L], 1'b0);
        reset_l = 1'b1;
        #1;
        chk("rst_field_rel", bus_in[BUS_FIELD_RESET_L], 1'b1);
        @(posedge clk);
        #1;
        chk("rdy_after_rst", cmd_ready, 1'b1);
        chk("clk_field_hi", bus_in[BUS_FIELD_CLK], 1'b1);
        @(negedge clk);
        chk("clk_field_lo", bus_in[BUS_FIELD_CLK], 1'b0);

        // irq pass-through
        irq_in = 1'b1;
        #1;
        chk("irq_hi", irq, 1'b1);
        irq_in = 1'b0;
        #1;
        chk("irq_lo", irq, 1'b0);

        // read, ack 4 cycles after request
        txn("rd4", 1'b0, 32'h100, 32'h0, 4'hF, 1, 4, 32'h12345678,
            5, 32'h12345678, 1'b0);
        // write, ack in first WAIT cycle
        txn("wr0", 1'b1, 32'h104, 32'hA5A5A5A5, 4'hF, 2, 0,
            32'hFFFF0000, 1, 32'h0, 1'b0);
        // read timeout, no ack
        txn("tmo", 1'b0, 32'h108, 32'h0, 4'h3, 0, 0, 32'hDEADBEEF,
            8, 32'h0, 1'b1);
        // late ack after timeout produces nothing
        rd_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rd_ack = 1'b0;
            chk("late_ack_rv", rsp_valid, 1'b0);
        end
        // ack collides with last timeout cycle: ack wins
        txn("coll", 1'b0, 32'h10C, 32'h0, 4'h1, 1, 7, 32'hCAFEF00D,
            8, 32'hCAFEF00D, 1'b0);
        // wrong-kind ack ignored, read times out
        txn("wrong", 1'b0, 32'h110, 32'h0, 4'hC, 2, 2, 32'h0BADBEEF,
            8, 32'h0, 1'b1);
        // write times out on a read ack
        txn("wr_wrong", 1'b1, 32'h114, 32'h5A5A5A5A, 4'h6, 1, 0,
            32'h11111111, 8, 32'h0, 1'b1);

        // reset in the 2nd WAIT cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rdreq", bus_in[BUS_FIELD_RD_REQ], 1'b1);
        @(negedge clk);
        rd_ack  = 1'b1;
        reset_l = 1'b0;
        #1;
        chk("mid_req0", req_fields(), '0);
        chk("mid_rdy", cmd_ready, 1'b1);
        chk("mid_rv", rsp_valid, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mid_rv_hold", rsp_valid, 1'b0);
        end
        rd_ack  = 1'b0;
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rdy_rel", cmd_ready, 1'b1);
        chk("mid_rv_rel", rsp_valid, 1'b0);
        txn("post_rst", 1'b0, 32'h300, 32'h0, 4'hF, 1, 1, 32'h87654321,
            2, 32'h87654321, 1'b0);

        // back-to-back with cmd_valid and ack held high
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h400;
        rd_ack    = 1'b1;
        slv_rdata = 32'h00C0FFEE;
        chk("b2b_rdy_0", cmd_ready, 1'b1);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            chk("b2b_rdy", cmd_ready, (k % 3) == 0);
            chk("b2b_rv", rsp_valid, (k % 3) == 2);
        end
        cmd_valid = 1'b0;
        rd_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_rdy", cmd_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
